// File: rtl/ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module      : ltc2308_responder
// Description : ADC-side responder for the LTC2308 CONVST/SCK/SDI/SDO link.
//               Oversamples the master's pins on clock, times a conversion,
//               shifts a 12-bit code out on SDO (MSB first) and captures the
//               6-bit config word from SDI. The captured word governs the next
//               conversion.
// Ports       : clock, reset          - system clock, sync active-high reset
//               CONVST, SCK, SDI      - asynchronous pins from the master
//               SDO                   - registered serial data to the master
//               sample_in[11:0]       - unsigned code returned per conversion
//               channel[3:0]          - {S/D,O/S,S1,S0} of the active config
//               sample_latched        - 1-cycle pulse when sample_in is taken
//               cfg_word[5:0]         - active {S/D,O/S,S1,S0,UNI,SLP}
//               busy                  - high while converting
//               error_flags[1:0]      - sticky protocol violations during CONV
// Revision    : 1.0 - initial release
// ============================================================================
module ltc2308_responder #(
    parameter int unsigned TCONV_CYCLES = 130,
    parameter logic [5:0]  CFG_RESET    = 6'b100010
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        CONVST,
    input  logic        SCK,
    input  logic        SDI,
    output logic        SDO,
    input  logic [11:0] sample_in,
    output logic [3:0]  channel,
    output logic        sample_latched,
    output logic [5:0]  cfg_word,
    output logic        busy,
    output logic [1:0]  error_flags
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_SLEEP = 2'd3;

    localparam int unsigned   TW         = $clog2(TCONV_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TCONV_CYCLES - 1);

    // Pin synchronizers: bits [1:0] are the 2-FF synchronizer, bit [2] holds
    // the previous synchronized value for edge detection.
    logic [2:0] cv_sync_q;
    logic [2:0] sck_sync_q;
    logic [1:0] sdi_sync_q;

    logic [1:0]    state_q,    state_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [11:0]   data_q,     data_d;
    logic [3:0]    fall_cnt_q, fall_cnt_d;
    logic [5:0]    cfg_sr_q,   cfg_sr_d;
    logic [2:0]    cfg_cnt_q,  cfg_cnt_d;
    logic [5:0]    cfg_word_q, cfg_word_d;
    logic          sdo_q,      sdo_d;
    logic          latched_q,  latched_d;
    logic [1:0]    err_q,      err_d;

    logic cv_rise;
    logic sck_rise;
    logic sck_fall;
    logic cfg_full;
    logic start;

    assign cv_rise  =  cv_sync_q[1]  & ~cv_sync_q[2];
    assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] &  sck_sync_q[2];
    assign cfg_full = (cfg_cnt_q == 3'd6);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        data_d     = data_q;
        fall_cnt_d = fall_cnt_q;
        cfg_sr_d   = cfg_sr_q;
        cfg_cnt_d  = cfg_cnt_q;
        cfg_word_d = cfg_word_q;
        sdo_d      = sdo_q;
        latched_d  = 1'b0;
        err_d      = err_q;
        start      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cv_rise) begin
                    start = 1'b1;
                end
            end
            ST_CONV: begin
                if (cv_rise) begin
                    err_d[0] = 1'b1;
                end
                if (sck_rise || sck_fall) begin
                    err_d[1] = 1'b1;
                end
                if (timer_q == '0) begin
                    // Present the MSB and pre-shift so data_q[11] is always
                    // the bit to show after the next SCK fall.
                    state_d    = ST_READ;
                    sdo_d      = data_q[11];
                    data_d     = {data_q[10:0], 1'b0};
                    fall_cnt_d = 4'd0;
                    cfg_cnt_d  = 3'd0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_READ: begin
                if (cv_rise) begin
                    // CONVST wins over any coincident SCK edge; a complete
                    // config still pending is committed on the way out.
                    if (cfg_full) begin
                        cfg_word_d = cfg_sr_q;
                    end
                    start = 1'b1;
                end else if (fall_cnt_q == 4'd12 && cfg_word_q[0]) begin
                    state_d = ST_SLEEP;
                    sdo_d   = 1'b0;
                end else begin
                    if (sck_rise && !cfg_full) begin
                        cfg_sr_d  = {cfg_sr_q[4:0], sdi_sync_q[1]};
                        cfg_cnt_d = cfg_cnt_q + 3'd1;
                    end
                    if (sck_fall && fall_cnt_q != 4'd12) begin
                        fall_cnt_d = fall_cnt_q + 4'd1;
                        data_d     = {data_q[10:0], 1'b0};
                        if (fall_cnt_q == 4'd11) begin
                            sdo_d = 1'b0;
                            if (cfg_full) begin
                                cfg_word_d = cfg_sr_q;
                            end
                        end else begin
                            sdo_d = data_q[11];
                        end
                    end
                end
            end
            default: begin // ST_SLEEP: first CONVST rise only wakes
                sdo_d = 1'b0;
                if (cv_rise) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Conversion start shared by IDLE and READ. The config that will be
        // active after this cycle decides the coding: bipolar flips the MSB.
        if (start) begin
            data_d    = {sample_in[11] ^ ~cfg_word_d[1], sample_in[10:0]};
            latched_d = 1'b1;
            timer_d   = TIMER_LOAD;
            sdo_d     = 1'b0;
            state_d   = ST_CONV;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cv_sync_q  <= '0;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            data_q     <= '0;
            fall_cnt_q <= '0;
            cfg_sr_q   <= '0;
            cfg_cnt_q  <= '0;
            cfg_word_q <= CFG_RESET;
            sdo_q      <= 1'b0;
            latched_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            cv_sync_q  <= {cv_sync_q[1:0], CONVST};
            sck_sync_q <= {sck_sync_q[1:0], SCK};
            sdi_sync_q <= {sdi_sync_q[0], SDI};
            state_q    <= state_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            fall_cnt_q <= fall_cnt_d;
            cfg_sr_q   <= cfg_sr_d;
            cfg_cnt_q  <= cfg_cnt_d;
            cfg_word_q <= cfg_word_d;
            sdo_q      <= sdo_d;
            latched_q  <= latched_d;
            err_q      <= err_d;
        end
    end

    assign SDO            = sdo_q;
    assign channel        = cfg_word_q[5:2];
    assign sample_latched = latched_q;
    assign cfg_word       = cfg_word_q;
    assign busy           = (state_q == ST_CONV);
    assign error_flags    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ltc2308_responder
// Description : Self-checking bench for ltc2308_responder. Acts as the ADC
//               master on the pins and predicts every result from a small
//               transaction-level model of the ADC (active config, sleep,
//               sticky errors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ltc2308_responder;

    localparam logic [5:0] CFG_RST = 6'b100010;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        CONVST = 1'b0;
    logic        SCK = 1'b0;
    logic        SDI = 1'b0;
    logic        SDO;
    logic [11:0] sample_in = '0;
    logic [3:0]  channel;
    logic        sample_latched;
    logic [5:0]  cfg_word;
    logic        busy;
    logic [1:0]  error_flags;

    int n_total = 0;
    int n_pass  = 0;

    // Transaction-level ADC model
    logic [5:0] m_cfg   = CFG_RST;
    logic       m_sleep = 1'b0;
    logic [1:0] m_err   = 2'b00;

    ltc2308_responder dut (
        .clock          (clock),
        .reset          (reset),
        .CONVST         (CONVST),
        .SCK            (SCK),
        .SDI            (SDI),
        .SDO            (SDO),
        .sample_in      (sample_in),
        .channel        (channel),
        .sample_latched (sample_latched),
        .cfg_word       (cfg_word),
        .busy           (busy),
        .error_flags    (error_flags)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // CONVST pulse followed by a fixed window long enough for a conversion;
    // optionally violates the protocol with an SCK pulse and a CONVST pulse
    // in the middle of the conversion.
    task automatic start_conv(input bit inject, output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        CONVST = 1'b1;
        for (int c = 0; c < 154; c++) begin
            if (c == 4) CONVST = 1'b0;
            if (inject) begin
                if (c == 24) SCK = 1'b1;
                if (c == 32) SCK = 1'b0;
                if (c == 44) CONVST = 1'b1;
                if (c == 48) CONVST = 1'b0;
            end
            cyc(1);
            lat = lat + int'(sample_latched);
            bsy = bsy + int'(busy);
        end
    endtask

    // Master readout: SDO is sampled just before each SCK falling edge.
    task automatic read_bits(input logic [5:0] c, input int nbits, output logic [11:0] w);
        w = '0;
        for (int i = 0; i < nbits; i++) begin
            SDI = (i < 6) ? c[5-i] : 1'($urandom_range(0, 1));
            SCK = 1'b1;
            cyc(8);
            w = {w[10:0], SDO};
            SCK = 1'b0;
            cyc(8);
        end
    endtask

    task automatic transact(input logic [11:0] s, input logic [5:0] c,
                            input int nbits, input bit inject);
        int         lat, bsy;
        logic [11:0] w, exp_w;
        logic [5:0]  vis_cfg;
        if (m_sleep) begin
            start_conv(1'b0, lat, bsy);
            chk("wake_latch", 32'(lat), 32'd0);
            chk("wake_busy", 32'(bsy), 32'd0);
            m_sleep = 1'b0;
        end
        sample_in = s;
        start_conv(inject, lat, bsy);
        chk("latch_pulses", 32'(lat), 32'd1);
        chk("busy_cycles", 32'(bsy), 32'd130);
        exp_w = m_cfg[1] ? s : (s ^ 12'h800);
        if (inject) m_err = 2'b11;
        read_bits(c, nbits, w);
        chk("read_word", 32'(w), 32'(exp_w >> (12 - nbits)));
        // A complete config takes effect at the 12th fall, or when READ is
        // left if the readout is cut short.
        vis_cfg = m_cfg;
        if (nbits >= 6) m_cfg = c;
        if (nbits == 12) vis_cfg = m_cfg;
        m_sleep = (nbits == 12) && m_cfg[0];
        cyc(4);
        if (nbits == 12) chk("sdo_after_read", 32'(SDO), 32'd0);
        chk("cfg_word", 32'(cfg_word), 32'(vis_cfg));
        chk("channel", 32'(channel), 32'(vis_cfg[5:2]));
        chk("error_flags", 32'(error_flags), 32'(m_err));
    endtask

    initial begin
        logic [11:0] w;
        int          lat, bsy;
        int          nb;

        // Reset state
        cyc(5);
        reset = 1'b0;
        cyc(1);
        chk("rst_sdo", 32'(SDO), 32'd0);
        chk("rst_latched", 32'(sample_latched), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(error_flags), 32'd0);
        chk("rst_cfg", 32'(cfg_word), 32'(CFG_RST));
        chk("rst_channel", 32'(channel), 32'h8);

        // Basic readout with config capture
        transact(12'hA5C, 6'b110010, 12, 1'b0);
        chk("channel_C", 32'(channel), 32'hC);

        // Bipolar coding on the conversion after a UNI=0 config
        transact(12'h123, 6'b000100, 12, 1'b0);
        transact(12'h000, 6'b110010, 12, 1'b0);

        // Protocol violations during CONV
        transact(12'($urandom), 6'b110010, 12, 1'b1);

        // Sleep, wake, convert
        transact(12'($urandom), 6'b100011, 12, 1'b0);
        transact(12'($urandom), 6'b100010, 12, 1'b0);

        // Randomized transactions including cut-short readouts
        for (int k = 0; k < 12; k++) begin
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 12;
            transact(12'($urandom), 6'($urandom), nb, 1'b0);
        end

        // Reset in the middle of a readout
        transact(12'hFFF, 6'b010101, 5, 1'b0);
        chk("pre_reset_sdo", 32'(SDO), 32'd1);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        m_cfg   = CFG_RST;
        m_err   = 2'b00;
        m_sleep = 1'b0;
        chk("mid_rst_sdo", 32'(SDO), 32'd0);
        chk("mid_rst_cfg", 32'(cfg_word), 32'(CFG_RST));
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(error_flags), 32'd0);
        transact(12'($urandom), 6'($urandom), 12, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
